// File: rtl/dec_n_seq.sv
// dec_n_seq: registered N-to-2^N one-hot decoder with three modes.
// LEVEL decodes sel every cycle. PULSE holds one output for PULSE_LEN cycles.
// SCAN walks the active output across all 2^N lines, PULSE_LEN cycles each.
// Optional feature macro: DEC_SCAN_EN enables SCAN mode. When it is
// undefined, mode 10 behaves as PULSE.
module dec_n_seq #(
  parameter int unsigned N         = 2,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    sel,
  input  logic [1:0]      mode,
  input  logic            load,
  output logic [2**N-1:0] out,
  output logic            busy,
  output logic            done
);

  localparam int unsigned W  = 2 ** N;
  localparam int unsigned DW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [N-1:0]    idx_q, idx_d;
`ifdef DEC_SCAN_EN
  logic [N:0]      step_q, step_d;
  logic            scan_q, scan_d;
`endif

  logic [W-1:0]    sel_hot, nxt_hot;
  logic [N-1:0]    idx_nxt;
  logic            dwell_last;
  logic            seq_mode;
  logic            finish;

  assign idx_nxt    = idx_q + 1'b1;  // wraps 2^N-1 -> 0
  assign sel_hot    = W'(1) << sel;
  assign nxt_hot    = W'(1) << idx_nxt;
  assign dwell_last = (dwell_q == DW'(PULSE_LEN - 1));
  assign seq_mode   = (mode == 2'b01) || (mode == 2'b10);

  // State register and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dwell_q <= '0;
      idx_q   <= '0;
`ifdef DEC_SCAN_EN
      step_q  <= '0;
      scan_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
`ifdef DEC_SCAN_EN
      step_q  <= step_d;
      scan_q  <= scan_d;
`endif
    end
  end

  // Next-state logic: level decode in IDLE, dwell/step sequencing in ACTIVE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dwell_d = dwell_q;
    idx_d   = idx_q;
    finish  = 1'b0;
`ifdef DEC_SCAN_EN
    step_d  = step_q;
    scan_d  = scan_q;
`endif
    unique case (state_q)
      StIdle: begin
        out_d   = '0;
        busy_d  = 1'b0;
        dwell_d = '0;
`ifdef DEC_SCAN_EN
        step_d  = '0;
`endif
        if (en && load && seq_mode) begin
          state_d = StActive;
          idx_d   = sel;
          out_d   = sel_hot;
          busy_d  = 1'b1;
`ifdef DEC_SCAN_EN
          scan_d  = (mode == 2'b10);
`endif
        end else if (en && !seq_mode) begin
          // LEVEL and reserved mode 11
          out_d = sel_hot;
        end
      end
      StActive: begin
        if (!en) begin
          // Abort: clear everything, no done
          state_d = StIdle;
          out_d   = '0;
          busy_d  = 1'b0;
          dwell_d = '0;
`ifdef DEC_SCAN_EN
          step_d  = '0;
`endif
        end else if (!dwell_last) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
`ifdef DEC_SCAN_EN
          if (scan_q && (step_q != (N+1)'(W - 1))) begin
            step_d  = step_q + 1'b1;
            idx_d   = idx_nxt;
            out_d   = nxt_hot;
            dwell_d = '0;
          end else begin
            finish = 1'b1;
          end
`else
          finish = 1'b1;
`endif
        end
        if (finish) begin
          state_d = StIdle;
          out_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dwell_d = '0;
`ifdef DEC_SCAN_EN
          step_d  = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dec_n_seq.sv
// Directed self-checking bench for dec_n_seq (N=2). Instance a uses
// PULSE_LEN=4, instance b uses PULSE_LEN=2; both share the stimulus.
module tb_dec_n_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] sel = '0;
  logic [1:0] mode = '0;
  logic       load = 1'b0;
  logic [3:0] out_a, out_b;
  logic       busy_a, busy_b, done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dec_n_seq #(.N(2), .PULSE_LEN(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .mode(mode), .load(load),
    .out(out_a), .busy(busy_a), .done(done_a)
  );

  dec_n_seq #(.N(2), .PULSE_LEN(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .mode(mode), .load(load),
    .out(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; sel = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] seq_exp [8];
  int         seq_len;

  initial begin
    // Reset
    do_reset();
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    check("rst_done_a", 32'(done_a), 32'h0);
    check("rst_out_b", 32'(out_b), 32'h0);

    // LEVEL decode
    en = 1'b1; mode = 2'b00; sel = 2'd2;
    step();
    check("level_out", 32'(out_a), 32'h4);
    check("level_busy", 32'(busy_a), 32'h0);
    sel = 2'd1; load = 1'b1;
    step();
    check("level_load_ign", 32'(out_a), 32'h2);
    check("level_load_busy", 32'(busy_a), 32'h0);
    load = 1'b0; en = 1'b0;
    step();
    check("level_en_off", 32'(out_a), 32'h0);
    // Reserved mode 11 behaves as LEVEL
    en = 1'b1; mode = 2'b11; sel = 2'd1; load = 1'b1;
    step();
    check("mode11_out", 32'(out_a), 32'h2);
    check("mode11_busy", 32'(busy_a), 32'h0);
    load = 1'b0;

    // PULSE on a: sel=3, second load at T+2 ignored
    do_reset();
    en = 1'b1; mode = 2'b01; sel = 2'd3; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("pulse_out_k%0d", k), 32'(out_a), (k <= 4) ? 32'h8 : 32'h0);
      check($sformatf("pulse_busy_k%0d", k), 32'(busy_a), (k <= 4) ? 32'h1 : 32'h0);
      check($sformatf("pulse_done_k%0d", k), 32'(done_a), (k == 5) ? 32'h1 : 32'h0);
      if (k == 2) begin
        load = 1'b1; sel = 2'd0;
      end else begin
        load = 1'b0;
      end
      step();
    end

    // Back-to-back restart in the done cycle, then reset mid-run
    do_reset();
    en = 1'b1; mode = 2'b01; sel = 2'd1; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    check("b2b_done", 32'(done_a), 32'h1);
    check("b2b_first_out", 32'(out_a), 32'h0);
    load = 1'b1; sel = 2'd2;
    step();
    load = 1'b0;
    check("b2b_out", 32'(out_a), 32'h4);
    check("b2b_busy", 32'(busy_a), 32'h1);
    check("b2b_done_low", 32'(done_a), 32'h0);
    rst = 1'b1; load = 1'b1;
    step();
    rst = 1'b0; load = 1'b0;
    check("midrst_out", 32'(out_a), 32'h0);
    check("midrst_busy", 32'(busy_a), 32'h0);
    check("midrst_done", 32'(done_a), 32'h0);

    // SCAN wrap on b (PULSE_LEN=2), sel=2
`ifdef DEC_SCAN_EN
    seq_exp = '{4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h2};
    seq_len = 8;
`else
    seq_exp = '{4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    seq_len = 2;
`endif
    do_reset();
    en = 1'b1; mode = 2'b10; sel = 2'd2; load = 1'b1;
    step();
    load = 1'b0; sel = 2'd0;  // sel changes during ACTIVE are ignored
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("scan_out_k%0d", k), 32'(out_b),
            (k <= seq_len) ? 32'(seq_exp[k-1]) : 32'h0);
      check($sformatf("scan_busy_k%0d", k), 32'(busy_b), (k <= seq_len) ? 32'h1 : 32'h0);
      check($sformatf("scan_done_k%0d", k), 32'(done_b), (k == seq_len + 1) ? 32'h1 : 32'h0);
      step();
    end

    // Abort on a: sequence from sel=0, en dropped at edge T+3
    do_reset();
    en = 1'b1; mode = 2'b10; sel = 2'd0; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("abort_out_k%0d", k), 32'(out_a), (k <= 3) ? 32'h1 : 32'h0);
      check($sformatf("abort_busy_k%0d", k), 32'(busy_a), (k <= 3) ? 32'h1 : 32'h0);
      check($sformatf("abort_done_k%0d", k), 32'(done_a), 32'h0);
      if (k == 3) en = 1'b0;
      step();
    end
    en = 1'b1; sel = 2'd3; load = 1'b1;
    step();
    load = 1'b0;
    check("reload_out", 32'(out_a), 32'h8);
    check("reload_busy", 32'(busy_a), 32'h1);

    // mode 10 with sel=1 on a: SCAN moves on, otherwise a single pulse
    do_reset();
    en = 1'b1; mode = 2'b10; sel = 2'd1; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("m10_out_k%0d", k), 32'(out_a), 32'h2);
      step();
    end
`ifdef DEC_SCAN_EN
    check("m10_after_out", 32'(out_a), 32'h4);
    check("m10_after_done", 32'(done_a), 32'h0);
`else
    check("m10_after_out", 32'(out_a), 32'h0);
    check("m10_after_done", 32'(done_a), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_n_seq.md
# dec_n_seq

Parametrised, registered N-to-2^N decoder with enable, one-hot output and three operating modes: level decode, timed one-shot pulse, and a timed scan that walks the active output across all 2^N lines. It is the sequential successor to the team's combinational 2-to-4 enable decoder. It drives chip-select, row-strobe and LED/segment-digit lines wherever a selected output must be held for a defined number of cycles rather than only decoded.

## Interface
Parameters:
- N, default 2: select width; output width is 2^N (N ≥ 1).
- PULSE_LEN, default 4: dwell time in cycles per active output in PULSE and SCAN modes (≥ 1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; low forces all outputs low and aborts any sequence.
- sel  input  N  select index.
- mode  input  2  00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved (behaves as LEVEL).
- load  input  1  start strobe for PULSE/SCAN; sampled only in IDLE.
- out  output  2^N  registered one-hot (or all-zero) output.
- busy  output  1  high while a PULSE/SCAN sequence is active.
- done  output  1  one-cycle pulse when a sequence completes normally.

## Operation
- Reset: state = IDLE, out = 0, busy = 0, done = 0, counters = 0.
- FSM states: IDLE, ACTIVE. Sel and mode are latched on load; changes to them during ACTIVE are ignored.
- LEVEL (IDLE only): out <= en ? (1 << sel) : 0 every cycle; busy and done stay 0; load is ignored.
- PULSE: in IDLE with en=1 and load=1: latch sel, enter ACTIVE, out = 1 << sel for PULSE_LEN cycles. Then out = 0, return to IDLE, and pulse done.
- SCAN: in IDLE with en=1 and load=1: latch sel as start index and enter ACTIVE. Output index k = start, start+1, … (mod 2^N), each held PULSE_LEN cycles, until all 2^N indices have been visited. Then out = 0, IDLE, done.
- Counters: dwell counter 0..PULSE_LEN-1; step counter 0..2^N-1, N+1 bits wide so that 2^N is representable. Index increment wraps from 2^N-1 to 0.
- Load while ACTIVE: ignored, with no queuing.
- en low in ACTIVE: abort on the next edge. out = 0, IDLE, done stays 0, counters cleared.
- en low in IDLE: load is ignored.
- Exactly one out bit is high whenever out is non-zero.

## Timing
- LEVEL: one-cycle latency from sel/en to out.
- PULSE, load sampled at edge T:
  - out and busy are high for cycles T+1 … T+PULSE_LEN.
  - At T+PULSE_LEN+1: out = 0, busy = 0, done = 1 for one cycle.
- SCAN, load sampled at edge T:
  - Index start+i is active in cycles T+1+i·PULSE_LEN … T+(i+1)·PULSE_LEN.
  - busy covers 2^N·PULSE_LEN cycles; done follows in the next cycle.
- Back-to-back: a load in the cycle where done = 1 is accepted, because the FSM is already IDLE. This gives a zero-gap restart.
- rst has priority over en, load and mode in the same cycle.

## Configuration
- DEC_SCAN_EN defined: SCAN mode is present, as described above.
- DEC_SCAN_EN undefined:
  - SCAN logic and the step counter are removed.
  - mode 10 behaves exactly as PULSE.
  - All other behaviour is unchanged.

## Test plan
- Reset / LEVEL: N=2, hold rst 2 cycles → out=0000, busy=0, done=0. Then en=1, mode=00, sel=2 → out=0100 one cycle later; en=0 → out=0000 next cycle.
- PULSE: PULSE_LEN=4, sel=3, load at T → out=1000 for T+1..T+4, done=1 at T+5 only. A second load at T+2 is ignored.
- SCAN wrap: DEC_SCAN_EN defined, PULSE_LEN=2, sel=2, load at T → out sequence 0100,0100,1000,1000,0001,0001,0010,0010, then done at T+9.
- Abort: SCAN started, en=0 at T+3 → out=0000 and busy=0 at T+4, no done. A reload with en=1 starts cleanly from the new sel.
- Back-to-back / reset mid-run: load asserted in the done cycle → new pulse begins next cycle. rst during ACTIVE → all outputs 0 the next cycle.
- Macro off: DEC_SCAN_EN undefined, mode=10, sel=1 → single 0010 pulse of PULSE_LEN cycles, then done.
